e_mdu: RTL

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu.sv | 122 ++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: issues mult/div/mthi/mtlo, holds results in
// pending registers during a fixed multi-cycle busy window, then commits HI/LO.
module e_mdu #(
  parameter int W       = 32,
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] E_Grs,
  input  logic [W-1:0] E_Grt,
  input  logic [2:0]   mdu_op,
  input  logic         Req,
  output logic         start,
  output logic         busy,
  output logic [W-1:0] HI,
  output logic [W-1:0] LO
);
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  localparam logic [3:0] MUL_LD = 4'(MUL_CYC);
  localparam logic [3:0] DIV_LD = 4'(DIV_CYC);

  logic [3:0]     cnt;
  logic [W-1:0]   pend_hi, pend_lo;
  logic           pend_vld;
  logic           issue_ok;
  op_e            op;

  logic [2*W-1:0] prod_s, prod_u;
  logic [W-1:0]   dvd_mag, dvs_mag, dvs_safe;
  logic [W-1:0]   q_u, r_u, q_mag, r_mag, q_s, r_s;
  logic [W-1:0]   res_hi, res_lo;
  logic           res_ok;
  logic [3:0]     cyc_ld;

  assign op       = op_e'(mdu_op);
  assign issue_ok = reset & ~Req & ~busy;
  assign start    = issue_ok & (op == OP_MULT || op == OP_MULTU ||
                                op == OP_DIV  || op == OP_DIVU);

  // Sign-extended 2W x 2W product truncated to 2W bits is the signed product.
  assign prod_s = {{W{E_Grs[W-1]}}, E_Grs} * {{W{E_Grt[W-1]}}, E_Grt};
  assign prod_u = {{W{1'b0}}, E_Grs} * {{W{1'b0}}, E_Grt};

  // Divisor forced nonzero so the divider never sees x/0; result is dropped.
  assign dvs_safe = (E_Grt == '0) ? W'(1) : E_Grt;
  assign q_u      = E_Grs / dvs_safe;
  assign r_u      = E_Grs % dvs_safe;

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign dvd_mag = E_Grs[W-1] ? (~E_Grs + W'(1)) : E_Grs;
  assign dvs_mag = dvs_safe[W-1] ? (~dvs_safe + W'(1)) : dvs_safe;
  assign q_mag   = dvd_mag / dvs_mag;
  assign r_mag   = dvd_mag % dvs_mag;
  assign q_s     = (E_Grs[W-1] ^ dvs_safe[W-1]) ? (~q_mag + W'(1)) : q_mag;
  assign r_s     = E_Grs[W-1] ? (~r_mag + W'(1)) : r_mag;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_ok = 1'b1;
    cyc_ld = MUL_LD;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        cyc_ld = DIV_LD;
        res_ok = |E_Grt;
        res_hi = r_s;
        res_lo = q_s;
      end
      OP_DIVU: begin
        cyc_ld = DIV_LD;
        res_ok = |E_Grt;
        res_hi = r_u;
        res_lo = q_u;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      busy     <= 1'b0;
      pend_hi  <= '0;
      pend_lo  <= '0;
      pend_vld <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else if (start) begin
      cnt      <= cyc_ld;
      busy     <= 1'b1;
      pend_hi  <= res_hi;
      pend_lo  <= res_lo;
      pend_vld <= res_ok;
    end else if (busy) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        busy     <= 1'b0;
        pend_vld <= 1'b0;
        if (pend_vld) begin
          HI <= pend_hi;
          LO <= pend_lo;
        end
      end
    end else if (issue_ok) begin
      if (op == OP_MTHI) HI <= E_Grs;
      if (op == OP_MTLO) LO <= E_Grs;
    end
  end
endmodule
